// File: rtl/ula_issue.sv
// Operand-issue stage in front of the ALU: register file, decode, writeback bypass
// and a one-deep registered operand bundle behind a valid/ready handshake.

module ula_issue_rdport #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0]                i_addr,
    input  logic [(2**AW)-1:0][DW-1:0]   i_rf,
    input  logic                         i_wb_en,
    input  logic [AW-1:0]                i_wb_reg,
    input  logic [DW-1:0]                i_wb_data,
    output logic [DW:0]                  o_data
);
    logic [DW-1:0] w_raw;

    // r0 is hard-wired to zero, so a nonzero address also gates the bypass
    always_comb begin
        if (i_addr == '0)
            w_raw = '0;
        else if (i_wb_en && (i_wb_reg == i_addr))
            w_raw = i_wb_data;
        else
            w_raw = i_rf[i_addr];
    end

    assign o_data = {w_raw[DW-1], w_raw};
endmodule

module ula_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [31:0]               instruction,
    input  logic                      wb_enable,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [DATA_WIDTH:0]       inputA,
    output logic [DATA_WIDTH:0]       inputB,
    output logic [5:0]                operation,
    output logic [REG_ADDR_WIDTH-1:0] dest_reg,
    output logic                      illegal
);
    localparam int NUM_RD  = 2;
    localparam int NUM_REG = 2 ** REG_ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH:0]       a;
        logic [DATA_WIDTH:0]       b;
        logic [5:0]                op;
        logic [REG_ADDR_WIDTH-1:0] dest;
    } bundle_t;

    logic [NUM_REG-1:0][DATA_WIDTH-1:0]     r_rf;
    bundle_t                                r_bundle;
    logic                                   r_vld;
    logic                                   r_illegal;

    logic [5:0]                             w_opc;
    logic [5:0]                             w_funct;
    logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0]  w_rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH:0]        w_rd_data;
    logic [DATA_WIDTH:0]                    w_imm;
    logic                                   w_accept;
    logic                                   w_legal;
    bundle_t                                w_next;
    logic                                   w_unused;

    assign w_opc        = instruction[31:26];
    assign w_funct      = instruction[5:0];
    assign w_rd_addr[0] = REG_ADDR_WIDTH'(instruction[25:21]);
    assign w_rd_addr[1] = REG_ADDR_WIDTH'(instruction[20:16]);
    assign w_imm        = {{(DATA_WIDTH + 1 - 16){instruction[15]}}, instruction[15:0]};
    assign w_unused     = ^instruction[10:6];

    // Port 0 serves rs, port 1 serves rt
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        ula_issue_rdport #(
            .DW (DATA_WIDTH),
            .AW (REG_ADDR_WIDTH)
        ) u_rd (
            .i_addr    (w_rd_addr[g]),
            .i_rf      (r_rf),
            .i_wb_en   (wb_enable),
            .i_wb_reg  (wb_reg),
            .i_wb_data (wb_data),
            .o_data    (w_rd_data[g])
        );
    end

    always_comb begin
        w_legal = 1'b0;
        w_next  = '0;
        w_next.a = w_rd_data[0];
        if (w_opc == 6'd0 && (w_funct == 6'd32 || w_funct == 6'd34 ||
                              w_funct == 6'd24 || w_funct == 6'd26)) begin
            w_legal     = 1'b1;
            w_next.op   = w_funct;
            w_next.b    = w_rd_data[1];
            w_next.dest = REG_ADDR_WIDTH'(instruction[15:11]);
        end else if (w_opc == 6'd8) begin
            w_legal     = 1'b1;
            w_next.op   = 6'd32;
            w_next.b    = w_imm;
            w_next.dest = w_rd_addr[1];
        end
    end

    assign instr_ready = !r_vld || issue_ready;
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rf      <= '0;
            r_bundle  <= '0;
            r_vld     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (wb_enable && (wb_reg != '0))
                r_rf[wb_reg] <= wb_data;
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_bundle <= w_next;
                r_vld    <= 1'b1;
            end else begin
                // Illegal accepts fall through here: the held bundle only survives if not consumed
                r_vld <= r_vld && !issue_ready;
            end
        end
    end

    assign issue_valid = r_vld;
    assign inputA      = r_bundle.a;
    assign inputB      = r_bundle.b;
    assign operation   = r_bundle.op;
    assign dest_reg    = r_bundle.dest;
    assign illegal     = r_illegal;
endmodule

// File: doc/ula_issue.md
Name: ula_issue

Overview:
- Operand-issue stage sitting directly upstream of the ALU (ula).
- Holds the 32x32 architectural register file and decodes one MIPS instruction per handshake.
- Reads and bypasses operands, then presents a registered {inputA, inputB, operation, dest_reg} bundle to the ALU through a valid/ready handshake.
- Writeback from the downstream stage returns through the wb_* port.

Parameters:
- DATA_WIDTH, 32, architectural register width; ALU operands are DATA_WIDTH+1 bits.
- REG_ADDR_WIDTH, 5, register index width; the file has 2**REG_ADDR_WIDTH entries.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- instr_valid  input  1  upstream instruction valid
- instr_ready  output  1  stage can accept an instruction this cycle
- instruction  input  32  MIPS instruction word
- wb_enable  input  1  register-file write strobe
- wb_reg  input  5  write index
- wb_data  input  32  write data
- issue_valid  output  1  operand bundle valid toward the ALU
- issue_ready  input  1  downstream consumes the bundle
- inputA  output  33  operand A, sign-extended
- inputB  output  33  operand B, sign-extended
- operation  output  6  ALU function code
- dest_reg  output  5  destination register for writeback
- illegal  output  1  one-cycle pulse: accepted instruction was unsupported and dropped

Behaviour:
- **Reset (async, reset_n=0):**
  - issue_valid=0, illegal=0.
  - inputA, inputB, operation and dest_reg = 0.
  - All registers = 0.
  - Any pending bundle is discarded. Resumes cleanly on the first edge after release.
- **Register file:**
  - r0 reads 0 always; writes to r0 are ignored.
  - On posedge with wb_enable=1 and wb_reg!=0: reg[wb_reg] <= wb_data.
- **Bypass:**
  - When an instruction is accepted in the same cycle that wb_enable=1, wb_reg!=0 and wb_reg matches rs (or rt), the operand uses wb_data, not the stale file value.
  - After capture, held operands never change, even if a later write hits the same register.
- **Decode** (opc=instruction[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]):
  - opc=0 and funct in {32,34,24,26}: operation=funct, A=reg[rs], B=reg[rt], dest_reg=rd.
  - opc=8 (addi): operation=32, A=reg[rs], B=sign-extended instruction[15:0], dest_reg=rt.
  - Anything else: illegal.
- **Width rule:** every 32-bit operand is extended to 33 bits by replicating bit 31 into bit 32. The addi immediate is sign-extended 16 to 33 bits.
- **Handshake:**
  - instr_ready = !issue_valid || issue_ready (combinational).
  - Accept = instr_valid && instr_ready, sampled on posedge.
  - Latency: exactly one cycle from accept to issue_valid=1.
- **Accept, legal instruction:** output registers load and issue_valid <= 1. Back-to-back accepts sustain one bundle per cycle while issue_ready=1.
- **Accept, illegal instruction:**
  - illegal <= 1 for one cycle; output registers are not loaded.
  - issue_valid <= 0 if the old bundle was consumed that cycle, otherwise it stays 1.
- **Consume with no accept:** if issue_valid && issue_ready and there is no accept, issue_valid <= 0.
- **Stall:** while issue_valid=1 and issue_ready=0, all outputs hold stable and instr_ready=0. A write to a source register during the stall does not alter the held operands.
- **No accept:** when instr_valid=0, illegal=0 and the outputs are unchanged except issue_valid as described above.

Test Plan:
1. **Reset and basic add.** Reset with reset_n low mid-stream, then release; write r1=5 and r2=7; issue add $3,$1,$2 (0x00221820). Required: issue_valid one cycle after accept, inputA=5, inputB=7, operation=32, dest_reg=3.
2. **addi sign extension.** r4=0x80000000; issue addi $5,$4,-1 (0x2085FFFF). Required: inputA=0x1_80000000, inputB=0x1_FFFFFFFF, operation=32, dest_reg=5.
3. **Bypass.** Write r6=9 in the same cycle that sub $7,$6,$0 is accepted, with r6 previously 1. Required: inputA=9, inputB=0, operation=34.
4. **Stall and held operands.** Hold issue_ready=0 for 4 cycles after a mult bundle issues, writing its rs register during the stall. Required: instr_ready=0, and inputA, inputB and operation=24 unchanged for all 4 cycles. Then raise issue_ready with a div queued: the bundle updates to operation=26 on the next cycle with no bubble.
5. **Illegal and r0 protection.** Issue an and instruction (funct 36), then opcode 2 (j). Required: illegal pulses one cycle each, issue_valid drops to 0 once the prior bundle is consumed, and no bundle is emitted. Then write r0=0xFFFFFFFF and issue add $1,$0,$0: required inputA=0, inputB=0.
6. **Reset mid-stall.** Assert reset_n=0 while issue_valid=1 and issue_ready=0. Required: issue_valid=0 and all outputs 0 immediately, without waiting for a clock edge. All registers read 0 afterwards.
